buffer_linea: RTL and testbench

Line-prefetch pixel stage between the `drom` image ROM and `controlador_vga`. On each display line it fetches one 100-pixel row of the selected quadrant tile into a 25-word line buffer. It then serves 8-bit pixels, upscaled ×4 in both axes, into a 400×400 window of the 640×480 frame. It replaces direct per-pixel ROM reads, so ROM latency never touches active video.

---
 rtl/buffer_linea.sv | 176 +++++++++++++++++
 tb/tb_buffer_linea.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_linea.sv
// buffer_linea: line-prefetch pixel stage between the image ROM and the VGA
// timing controller. One 100-pixel tile row is fetched into a 25-word line
// buffer during horizontal blanking. Pixels are then served from that buffer,
// upscaled x4 in both axes, inside a 400x400 window.
module buffer_linea #(
   parameter int WIN_X  = 120,
   parameter int WIN_Y  = 40,
   parameter int ADDR_W = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [4:0]        quadrant,
   input  logic              line_req,
   input  logic [9:0]        line_y,
   input  logic [9:0]        pixel_x,
   input  logic [9:0]        pixel_y,
   input  logic              active,
   output logic [ADDR_W-1:0] rom_address,
   input  logic [31:0]       rom_data,
   output logic [7:0]        pixel,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Window limits in the 10-bit coordinate space of the timing generator.
   localparam logic [9:0] X_LO = 10'(WIN_X);
   localparam logic [9:0] X_HI = 10'(WIN_X + 400);
   localparam logic [9:0] Y_LO = 10'(WIN_Y);
   localparam logic [9:0] Y_HI = 10'(WIN_Y + 400);

   // 25 words per tile row; these markers never match a legal row/quadrant.
   localparam logic [4:0] LAST_WORD = 5'd24;
   localparam logic [6:0] ROW_NONE  = 7'h7F;
   localparam logic [4:0] QUAD_NONE = 5'h1F;

   state_t      state;
   logic        valid;
   logic [6:0]  row_reg;
   logic [4:0]  quad_reg;
   logic [4:0]  cnt;
   // pend marks that rom_data in this cycle belongs to word pend_idx.
   logic        pend;
   logic [4:0]  pend_idx;

   logic [31:0] line_mem [25];

   logic              line_in_win;
   logic              quad_ok;
   logic [6:0]        req_row;
   logic              need_fetch;
   logic [ADDR_W-1:0] base_addr;

   logic        pix_in_win;
   logic [6:0]  col;
   logic [4:0]  word_idx;
   logic [1:0]  lane;
   logic [31:0] rd_word;
   logic [7:0]  lane_byte [4];
   logic [7:0]  pix_next;

   // Decide at line_req whether the buffer must be (re)loaded and from where.
   always_comb begin
      line_in_win = (line_y >= Y_LO) && (line_y < Y_HI);
      quad_ok     = ~quadrant[4];
      req_row     = 7'((line_y - Y_LO) >> 2);
      need_fetch  = line_in_win && quad_ok &&
                    (!valid || (req_row != row_reg) || (quadrant != quad_reg));
      // Tile row r starts at image line tile_r*100 + r; each line is 100 words.
      base_addr   = ADDR_W'((32'(quadrant[3:2]) * 32'd100 + 32'(req_row)) * 32'd100
                            + 32'(quadrant[1:0]) * 32'd25);
   end

   // Fetch sequencer: issues 25 consecutive addresses, then waits one cycle
   // for the last ROM word. A new line_req always wins over a fetch in flight.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         rom_address <= '0;
         busy        <= 1'b0;
         valid       <= 1'b0;
         row_reg     <= ROW_NONE;
         quad_reg    <= QUAD_NONE;
         cnt         <= 5'd0;
         pend        <= 1'b0;
         pend_idx    <= 5'd0;
      end else if (line_req && need_fetch) begin
         // Start (or restart) at word 0; the word still in flight is dropped.
         state       <= ISSUE;
         rom_address <= base_addr;
         cnt         <= 5'd0;
         busy        <= 1'b1;
         valid       <= 1'b0;
         row_reg     <= req_row;
         quad_reg    <= quadrant;
         pend        <= 1'b0;
      end else if (line_req && (state != IDLE)) begin
         // Aborted fetch with nothing to load: buffer stays invalid.
         state <= IDLE;
         busy  <= 1'b0;
         pend  <= 1'b0;
         if (!quad_ok) begin
            valid <= 1'b0;
         end
      end else begin
         if (line_req && !quad_ok) begin
            valid <= 1'b0;
         end
         case (state)
            ISSUE: begin
               pend     <= 1'b1;
               pend_idx <= cnt;
               if (cnt == LAST_WORD) begin
                  state <= DRAIN;
               end else begin
                  cnt         <= cnt + 5'd1;
                  rom_address <= rom_address + 1'b1;
               end
            end
            DRAIN: begin
               pend  <= 1'b0;
               busy  <= 1'b0;
               valid <= 1'b1;
               state <= IDLE;
            end
            default: begin
               pend <= 1'b0;
            end
         endcase
      end
   end

   // Line buffer write port: capture the ROM word one cycle after its address.
   always_ff @(posedge clock) begin
      if (pend) begin
         line_mem[pend_idx] <= rom_data;
      end
   end

   // Map the screen column onto a buffer word and byte lane (x4 upscale).
   always_comb begin
      pix_in_win = active &&
                   (pixel_x >= X_LO) && (pixel_x < X_HI) &&
                   (pixel_y >= Y_LO) && (pixel_y < Y_HI);
      col      = 7'((pixel_x - X_LO) >> 2);
      word_idx = col[6:2];
      lane     = col[1:0];
      rd_word  = line_mem[word_idx];
   end

   // Byte 0 of each word is the leftmost of its four pixels.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign lane_byte[gi] = rd_word[8*gi +: 8];
      end
   endgenerate

   // Black outside the window or while the buffer holds no valid row.
   always_comb begin
      pix_next = (pix_in_win && valid) ? lane_byte[lane] : 8'd0;
   end

   // Registered pixel output, one cycle behind the timing inputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pixel <= 8'd0;
      end else begin
         pixel <= pix_next;
      end
   end

endmodule

// File: tb/tb_buffer_linea.sv
// Testbench for buffer_linea: table-driven vectors, hand-written abort and
// reset sequences, and randomized lines checked against an image-level model.
module tb_buffer_linea;

   logic        clock;
   logic        reset;
   logic [4:0]  quadrant;
   logic        line_req;
   logic [9:0]  line_y;
   logic [9:0]  pixel_x;
   logic [9:0]  pixel_y;
   logic        active;
   logic [15:0] rom_address;
   logic [31:0] rom_data;
   logic [7:0]  pixel;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   // Model of what the buffer currently holds, in image terms.
   bit m_valid;
   int m_quad;
   int m_row;

   typedef struct {
      int q;
      int ly;
      int px;
      int py;
      bit act;
      bit fetch;
      int base;
      bit zero;
      int word;
      int lane;
   } vec_t;

   vec_t tbl[15];

   buffer_linea #(.WIN_X(120), .WIN_Y(40), .ADDR_W(16)) dut (
      .clock       (clock),
      .reset       (reset),
      .quadrant    (quadrant),
      .line_req    (line_req),
      .line_y      (line_y),
      .pixel_x     (pixel_x),
      .pixel_y     (pixel_y),
      .active      (active),
      .rom_address (rom_address),
      .rom_data    (rom_data),
      .pixel       (pixel),
      .busy        (busy)
   );

   initial begin
      clock = 1'b0;
      forever #20 clock = ~clock;
   end

   function automatic logic [31:0] rom_fn(input int a);
      logic [31:0] h;
      h = 32'(a) * 32'h9E3779B1;
      h = h ^ (h >> 15) ^ 32'(a) ^ 32'h01010101;
      return h;
   endfunction

   // Synchronous ROM with one cycle of read latency.
   always @(posedge clock) rom_data <= rom_fn(int'(rom_address));

   function automatic logic [7:0] rom_byte(input int word, input int ln);
      logic [31:0] w;
      w = rom_fn(word);
      return w[8*ln +: 8];
   endfunction

   // Pixel of the 400x400 image shown at screen (px,py) given the stored tile row.
   function automatic logic [7:0] ref_pixel(input int px, input int py, input bit act);
      int img_y, img_x;
      if (!act || !m_valid || px < 120 || px >= 520 || py < 40 || py >= 440) return 8'd0;
      img_y = (m_quad / 4) * 100 + m_row;
      img_x = (m_quad % 4) * 100 + (px - 120) / 4;
      return rom_byte(img_y * 100 + img_x / 4, img_x % 4);
   endfunction

   task automatic predict(input int q, input int ly, output bit fetch, output int base);
      int r;
      r = (ly - 40) / 4;
      fetch = (q < 16) && (ly >= 40) && (ly < 440) &&
              (!m_valid || q != m_quad || r != m_row);
      base = ((q / 4) * 100 + r) * 100 + ((q % 4) * 100) / 4;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_update(input int q, input int ly, input bit fetch);
      if (q >= 16) m_valid = 1'b0;
      else if (fetch) begin
         m_valid = 1'b1;
         m_quad  = q;
         m_row   = (ly - 40) / 4;
      end
   endtask

   // Called in cycle t+1 with line_req already dropped: follows one fetch.
   task automatic follow_fetch(input bit fetch, input int base);
      for (int k = 0; k < 26; k++) begin
         check("busy", busy, fetch);
         if (fetch && k < 25) check("rom_address", rom_address, base + k);
         @(negedge clock);
      end
      check("busy_end", busy, 0);
   endtask

   task automatic do_line(input int q, input int ly, input bit fetch, input int base);
      @(negedge clock);
      quadrant = q[4:0];
      line_y   = ly[9:0];
      line_req = 1'b1;
      $display("line q=%0d y=%0d fetch=%0d base=%0d", q, ly, fetch, base);
      @(negedge clock);
      line_req = 1'b0;
      follow_fetch(fetch, base);
      model_update(q, ly, fetch);
   endtask

   task automatic check_pix(input string name, input int px, input int py,
                            input bit act, input logic [7:0] exp);
      @(negedge clock);
      pixel_x = px[9:0];
      pixel_y = py[9:0];
      active  = act;
      @(negedge clock);
      active  = 1'b0;
      $display("pixel x=%0d y=%0d act=%0d got=%0d want=%0d", px, py, act, pixel, exp);
      check(name, pixel, exp);
   endtask

   initial begin
      #10ms;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bit f;
      int b, q, ly, px, py;
      bit act;
      logic [7:0] e;

      reset = 1'b0;
      quadrant = 5'd0; line_req = 1'b0; line_y = 10'd0;
      pixel_x = 10'd0; pixel_y = 10'd0; active = 1'b0;
      m_valid = 1'b0; m_quad = -1; m_row = -1;

      tbl[0]  = '{5,  48,  140, 48,  1, 1, 10225, 0, 10226, 1};
      tbl[1]  = '{5,  49,  120, 49,  1, 0, 0,     0, 10225, 0};
      tbl[2]  = '{5,  50,  519, 50,  1, 0, 0,     0, 10249, 3};
      tbl[3]  = '{5,  51,  119, 51,  1, 0, 0,     1, 0,     0};
      tbl[4]  = '{5,  52,  135, 52,  1, 1, 10325, 0, 10325, 3};
      tbl[5]  = '{5,  52,  200, 52,  0, 0, 0,     1, 0,     0};
      tbl[6]  = '{0,  40,  120, 40,  1, 1, 0,     0, 0,     0};
      tbl[7]  = '{15, 439, 519, 439, 1, 1, 39975, 0, 39999, 3};
      tbl[8]  = '{15, 440, 300, 439, 1, 0, 0,     0, 39986, 1};
      tbl[9]  = '{17, 100, 300, 100, 1, 0, 0,     1, 0,     0};
      tbl[10] = '{15, 439, 300, 439, 1, 1, 39975, 0, 39986, 1};
      tbl[11] = '{15, 20,  300, 20,  1, 0, 0,     1, 0,     0};
      tbl[12] = '{6,  100, 124, 100, 1, 1, 11550, 0, 11550, 1};
      tbl[13] = '{6,  103, 300, 440, 1, 0, 0,     1, 0,     0};
      tbl[14] = '{6,  101, 520, 101, 1, 0, 0,     1, 0,     0};

      // Reset state and pixel requests before any fetch.
      repeat (3) @(negedge clock);
      check("reset_pixel", pixel, 0);
      check("reset_busy", busy, 0);
      check("reset_rom_address", rom_address, 0);
      reset = 1'b1;
      check_pix("pix_before_fetch", 200, 100, 1, 8'd0);
      do_line(5, 20, 0, 0);
      check_pix("pix_invalid_line20", 300, 100, 1, 8'd0);

      // Table-driven vectors.
      for (int i = 0; i < 15; i++) begin
         do_line(tbl[i].q, tbl[i].ly, tbl[i].fetch, tbl[i].base);
         e = tbl[i].zero ? 8'd0 : rom_byte(tbl[i].word, tbl[i].lane);
         check_pix($sformatf("tbl%0d_pixel", i), tbl[i].px, tbl[i].py, tbl[i].act, e);
      end

      // Abort at t+10 and restart with line 52.
      @(negedge clock);
      quadrant = 5'd5; line_y = 10'd48; line_req = 1'b1;
      @(negedge clock);
      line_req = 1'b0;
      for (int k = 0; k < 9; k++) begin
         check("abort_first_addr", rom_address, 10225 + k);
         @(negedge clock);
      end
      check("abort_busy_t10", busy, 1);
      line_y = 10'd52; line_req = 1'b1;
      $display("abort restart at t+10 with y=52");
      @(negedge clock);
      line_req = 1'b0;
      follow_fetch(1, 10325);
      model_update(5, 52, 1);
      for (int w = 0; w < 25; w++) begin
         check_pix($sformatf("abort_word%0d", w), 120 + 4 * (4 * w + (w % 4)), 52, 1,
                   rom_byte(10325 + w, w % 4));
      end

      // Quadrant changed without line_req: output unchanged.
      quadrant = 5'd9;
      check_pix("quad_change_no_req", 135, 53, 1, rom_byte(10325, 3));
      quadrant = 5'd17;
      check_pix("quad17_no_req", 519, 53, 1, rom_byte(10349, 3));
      do_line(17, 60, 0, 0);
      for (int i = 0; i < 4; i++) check_pix("quad17_black", 120 + 100 * i, 60, 1, 8'd0);

      // Reset asserted at t+12 of a fetch.
      @(negedge clock);
      quadrant = 5'd5; line_y = 10'd48; line_req = 1'b1;
      @(negedge clock);
      line_req = 1'b0;
      pixel_x = 10'd140; pixel_y = 10'd48; active = 1'b1;
      repeat (11) @(negedge clock);
      check("pre_reset_busy", busy, 1);
      reset = 1'b0;
      #1;
      check("midreset_busy", busy, 0);
      check("midreset_pixel", pixel, 0);
      check("midreset_rom_address", rom_address, 0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      active = 1'b0;
      m_valid = 1'b0; m_quad = -1; m_row = -1;
      check_pix("post_reset_pixel", 140, 48, 1, 8'd0);
      do_line(5, 48, 1, 10225);
      check_pix("post_reset_refetch", 140, 48, 1, rom_byte(10226, 1));

      // Randomized lines against the image-level model.
      for (int it = 0; it < 40; it++) begin
         if (m_valid && $urandom_range(0, 2) == 0) begin
            q  = m_quad;
            ly = 40 + m_row * 4 + int'($urandom_range(0, 3));
         end else begin
            q  = int'($urandom_range(0, 19));
            ly = ($urandom_range(0, 3) != 0) ? int'($urandom_range(40, 439))
                                              : int'($urandom_range(0, 479));
         end
         predict(q, ly, f, b);
         do_line(q, ly, f, b);
         for (int j = 0; j < 3; j++) begin
            px  = int'($urandom_range(110, 530));
            py  = ($urandom_range(0, 3) != 0) ? ly : int'($urandom_range(0, 479));
            act = ($urandom_range(0, 3) != 0);
            check_pix("rand_pixel", px, py, act, ref_pixel(px, py, act));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
